instruction_queue: RTL
======================

# instruction_queue

Decoupling buffer between the Fetch stage and Decode. Fetch pushes each instruction and its PC into a small circular FIFO. Decode pops entries through a valid/ready handshake. The queue absorbs Decode stalls without losing fetched instructions, and its `inReady` output drives the Fetch `enable` input. A `flush` input discards every buffered entry on a taken branch or jump.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of the PC carried with each instruction
- `INSTRUCTION_WIDTH`, 32, instruction word width
- `DEPTH`, 4, number of entries; power of two, minimum 2

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; low forces reset state immediately
- `inInstruction`  in  INSTRUCTION_WIDTH  instruction from Fetch
- `inPC`  in  PC_WIDTH  PC of `inInstruction`
- `inValid`  in  1  Fetch presents an entry
- `inReady`  out  1  queue accepts a push this cycle; connects to Fetch `enable`
- `flush`  in  1  discard all entries; synchronous
- `outInstruction`  out  INSTRUCTION_WIDTH  head entry instruction
- `outPC`  out  PC_WIDTH  head entry PC
- `outValid`  out  1  head entry is valid
- `outReady`  in  1  Decode consumes head this cycle
- `count`  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- **Storage:** `DEPTH` entries of {PC, instruction}.
- **Pointers:** write pointer and read pointer, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty when the pointers are fully equal.
  - Full when the index bits are equal and the wrap bits differ.
- **Push:** occurs when `inValid && inReady && !flush`.
  - Writes the entry at the write pointer.
  - Increments the write pointer modulo 2·DEPTH.
- **Pop:** occurs when `outValid && outReady && !flush`. Increments the read pointer modulo 2·DEPTH.
- **Derived outputs:**
  - `inReady = !full`. A push is refused when full, even if a pop occurs in the same cycle; there is no full-queue pass-through.
  - `outValid = !empty`.
  - `outInstruction` and `outPC` are combinational reads of the head entry. When empty they hold the last head value; their content is don't-care.
- **Count:**
  - `count` = write pointer − read pointer, modulo 2·DEPTH, range 0..DEPTH.
  - Simultaneous push and pop leaves `count` unchanged.
- **Flush:** has priority over push and pop.
  - Next cycle both pointers are 0 and `count` is 0.
  - A same-cycle push is dropped and a same-cycle pop is not counted.
  - Storage contents are not cleared.
- **Wrap-around:** pointer index wraps DEPTH−1 → 0 and toggles the wrap bit. Occupancy stays correct across any number of wraps.
- **Control state:** the empty/partial/full conditions are derived from the pointers; no separate FSM register is used.

## Timing
- **Reset:** `reset` low asynchronously sets both pointers to 0.
  - Resulting outputs: `count`=0, `outValid`=0, `inReady`=1.
  - `outInstruction` and `outPC` reset to 0; storage resets to 0.
- **Reset mid-operation:** all buffered entries are lost and outputs return to reset values immediately. Release is synchronous to `clock` (reset is sampled deasserted at an edge).
- **Push to visibility:** an entry pushed at edge N is visible on `outValid`/`outInstruction` after edge N. Latency is one cycle.
- **Pop:** an entry popped at edge N means the next entry, if any, is presented after edge N.
- **Backpressure:** `inReady` falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from full. Fetch therefore holds its PC for exactly the full cycles.
- **Flush:** `flush` at edge N gives `outValid`=0 and `inReady`=1 after edge N. A push at edge N+1 is accepted normally.

## Structure
- **Shared package `pipeline_pkg`:**
  - `fetch_entry_t` packed struct {pc, instruction}.
  - Default `PC_WIDTH`, `INSTRUCTION_WIDTH` and `QUEUE_DEPTH` constants, reused by the Fetch and Decode stages.
- **Sub-module `queue_pointer`:** parameterised wrap-bit counter with reset, clear (flush) and increment inputs. Instantiated twice, once for write and once for read.
- **Top level:** storage array, full/empty/count logic and the handshake gating.

## Test plan
- **Fill and drain:** reset, push 0x11..0x44 at PCs 0..3 with `outReady`=0.
  - After 4 pushes: `count`=4, `inReady`=0, a 5th push of 0x55 is ignored.
  - Then `outReady`=1: pops 0x11, 0x22, 0x33, 0x44 in order, then `outValid`=0.
- **Wrap-around:** 10 consecutive push-and-pop cycles with DEPTH=4, instructions 1..10.
  - Outputs 1..10 in order, one cycle behind input.
  - `count` holds at 1 throughout, and across pointer wrap.
- **Full with simultaneous pop:** queue full, `inValid`=1, `outReady`=1.
  - The pop occurs and the push is refused.
  - Next cycle `count`=3 and `inReady`=1.
- **Flush priority:** queue holds 3 entries; assert `flush` with `inValid`=1 and `outReady`=1.
  - Next cycle `count`=0 and `outValid`=0.
  - A following push of 0xAB is the head, `count`=1.
- **Asynchronous reset mid-operation:** 2 entries buffered; drop `reset` between clock edges.
  - `outValid`=0, `count`=0 and `inReady`=1 immediately, before the next edge.
  - After release, normal pushes resume.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared Fetch/Decode pipeline types and default widths.
// The instruction queue and the stages on either side of it use these defaults.
package pipeline_pkg;

  localparam int DEFAULT_PC_WIDTH          = 32;
  localparam int DEFAULT_INSTRUCTION_WIDTH = 32;
  localparam int QUEUE_DEPTH               = 4;

  typedef struct packed {
    logic [DEFAULT_PC_WIDTH-1:0]          pc;
    logic [DEFAULT_INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/queue_pointer.sv
// Wrap-bit FIFO pointer. It counts modulo 2*DEPTH, and the MSB toggles on each pass through the storage.
// A clear input forces the pointer to zero and takes priority over increment.
module queue_pointer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   inc_i,
  output logic [$clog2(DEPTH):0] ptr_o
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i)
      ptr_d = '0;
    else if (inc_i)
      ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/instruction_queue.sv
// Fetch-to-Decode decoupling FIFO that carries {PC, instruction} entries.
// inReady drives the Fetch enable input, and flush discards every buffered entry.
module instruction_queue
  import pipeline_pkg::*;
#(
  parameter int PC_WIDTH          = DEFAULT_PC_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int DEPTH             = QUEUE_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [INSTRUCTION_WIDTH-1:0] inInstruction,
  input  logic [PC_WIDTH-1:0]          inPC,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic                         flush,
  output logic [INSTRUCTION_WIDTH-1:0] outInstruction,
  output logic [PC_WIDTH-1:0]          outPC,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW:0]   wptr, rptr;
  logic          full, empty, push, pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // A pop in the same cycle does not open a slot: a full queue always refuses the push.
  assign push = inValid && !full && !flush;
  assign pop  = outReady && !empty && !flush;

  queue_pointer #(.DEPTH(DEPTH)) u_wptr (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (flush),
    .inc_i   (push),
    .ptr_o   (wptr)
  );

  queue_pointer #(.DEPTH(DEPTH)) u_rptr (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (flush),
    .inc_i   (pop),
    .ptr_o   (rptr)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr[AW-1:0]] <= '{pc: inPC, instruction: inInstruction};
    end
  end

  assign head           = mem_q[rptr[AW-1:0]];
  assign outInstruction = head.instruction;
  assign outPC          = head.pc;
  assign outValid       = !empty;
  assign inReady        = !full;
  assign count          = wptr - rptr;

endmodule
